// File: rtl/pipe_stage_reg_pkg.sv
// Shared defines for the pipeline stage register.
//   RstEnable_n : level of rst that holds the stage in reset (active low)
//   Stop/NoStop : values of a stall-vector bit
//   StallW      : width of the pipeline stall vector
//   stage_act_e : the single action a stage register performs on a clock edge
package pipe_stage_reg_pkg;

   localparam logic RstEnable_n = 1'b0;
   localparam logic Stop        = 1'b1;
   localparam logic NoStop      = 1'b0;

   localparam int unsigned StallW = 6;

   typedef enum logic [1:0] {
      ActFlush,
      ActBubble,
      ActAdvance,
      ActHold
   } stage_act_e;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Handshake/payload bundle between the pipeline controller and one stage register.
//   master : drives stall, flush, in_valid, in_pld, mc_i, mc_cnt_i, cnt_clr;
//            observes out_valid, out_pld, mc_o, mc_cnt_o, bubble_cnt
//   slave  : the stage register itself (directions reversed)
interface pipe_stage_reg_if
   import pipe_stage_reg_pkg::*;
#(
   parameter int unsigned DATA_W = 175,
   parameter int unsigned MC_W   = 64,
   parameter int unsigned CNT_W  = 2,
   parameter int unsigned BCNT_W = 16
);

   logic [StallW-1:0] stall;
   logic              flush;
   logic              in_valid;
   logic [DATA_W-1:0] in_pld;
   logic [MC_W-1:0]   mc_i;
   logic [CNT_W-1:0]  mc_cnt_i;
   logic              cnt_clr;
   logic              out_valid;
   logic [DATA_W-1:0] out_pld;
   logic [MC_W-1:0]   mc_o;
   logic [CNT_W-1:0]  mc_cnt_o;
   logic [BCNT_W-1:0] bubble_cnt;

   modport master (
      output stall, flush, in_valid, in_pld, mc_i, mc_cnt_i, cnt_clr,
      input  out_valid, out_pld, mc_o, mc_cnt_o, bubble_cnt
   );

   modport slave (
      input  stall, flush, in_valid, in_pld, mc_i, mc_cnt_i, cnt_clr,
      output out_valid, out_pld, mc_o, mc_cnt_o, bubble_cnt
   );

endinterface

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk : clock          rst : async active-low reset
//   inc : count by one   clr : clear to zero (wins over inc)
//   q   : count, sticks at all-ones
module sat_counter
   import pipe_stage_reg_pkg::*;
#(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] q
);

   logic [W-1:0] r_q;

   always_ff @(posedge clk or negedge rst) begin
      if (rst == RstEnable_n) begin
         r_q <= '0;
      end else if (clr) begin
         r_q <= '0;
      end else if (inc && (r_q != {W{1'b1}})) begin
         r_q <= r_q + 1'b1;
      end
   end

   assign q = r_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with flush, bubble insertion, hold, and multi-cycle
// operand feedback, plus a saturating count of inserted bubbles.
//   clk : clock          rst : async active-low reset
//   bus : pipe_stage_reg_if.slave (stall/flush/in_*/mc_*_i/cnt_clr in,
//         out_valid/out_pld/mc_o/mc_cnt_o/bubble_cnt out)
module pipe_stage_reg
   import pipe_stage_reg_pkg::*;
#(
   parameter int unsigned DATA_W          = 175,
   parameter int unsigned MC_W            = 64,
   parameter int unsigned CNT_W           = 2,
   parameter int unsigned STAGE_IDX       = 3,
   parameter bit          CLEAR_ON_BUBBLE = 1'b1,
   parameter int unsigned BCNT_W          = 16
) (
   input logic              clk,
   input logic              rst,
   pipe_stage_reg_if.slave  bus
);

   logic              w_s;
   logic              w_n;
   logic              w_bubble;
   stage_act_e        w_act;
   logic [BCNT_W-1:0] w_bubble_cnt;

   logic              r_valid;
   logic [DATA_W-1:0] r_pld;
   logic [MC_W-1:0]   r_mc;
   logic [CNT_W-1:0]  r_mc_cnt;

   assign w_s = bus.stall[STAGE_IDX];
   assign w_n = bus.stall[STAGE_IDX+1];

   always_comb begin
      w_act = ActHold;
      if (bus.flush) begin
         w_act = ActFlush;
      end else if (w_s == Stop && w_n == NoStop) begin
         w_act = ActBubble;
      end else if (w_s == NoStop) begin
         w_act = ActAdvance;
      end
   end

   assign w_bubble = (w_act == ActBubble);

   // Multi-cycle state is only captured while this stage is stopped; any
   // advance or flush drops it so the next instruction starts fresh.
   always_ff @(posedge clk or negedge rst) begin
      if (rst == RstEnable_n) begin
         r_valid  <= 1'b0;
         r_pld    <= '0;
         r_mc     <= '0;
         r_mc_cnt <= '0;
      end else begin
         unique case (w_act)
            ActFlush: begin
               r_valid  <= 1'b0;
               r_pld    <= '0;
               r_mc     <= '0;
               r_mc_cnt <= '0;
            end
            ActBubble: begin
               r_valid  <= 1'b0;
               if (CLEAR_ON_BUBBLE) begin
                  r_pld <= '0;
               end
               r_mc     <= bus.mc_i;
               r_mc_cnt <= bus.mc_cnt_i;
            end
            ActAdvance: begin
               r_valid  <= bus.in_valid;
               r_pld    <= bus.in_pld;
               r_mc     <= '0;
               r_mc_cnt <= '0;
            end
            ActHold: begin
               r_mc     <= bus.mc_i;
               r_mc_cnt <= bus.mc_cnt_i;
            end
            default: begin
               r_valid <= 1'b0;
            end
         endcase
      end
   end

   sat_counter #(
      .W (BCNT_W)
   ) u_bubble_cnt (
      .clk (clk),
      .rst (rst),
      .inc (w_bubble),
      .clr (bus.cnt_clr),
      .q   (w_bubble_cnt)
   );

   assign bus.out_valid  = r_valid;
   assign bus.out_pld    = r_pld;
   assign bus.mc_o       = r_mc;
   assign bus.mc_cnt_o   = r_mc_cnt;
   assign bus.bubble_cnt = w_bubble_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: two instances (stage 3 clearing on bubble with a
// 4-bit counter, stage 1 holding payload on bubble with a 16-bit counter)
// share one stimulus stream and are checked against a reference model.
module tb_pipe_stage_reg;

   localparam int unsigned DW = 175;
   localparam int unsigned MW = 64;
   localparam int unsigned CW = 2;

   logic clk;
   logic rst_n;

   logic [5:0]    stall;
   logic          flush;
   logic          in_valid;
   logic [DW-1:0] in_pld;
   logic [MW-1:0] mc_i;
   logic [CW-1:0] mc_cnt_i;
   logic          cnt_clr;

   int n_checks;
   int n_fail;

   pipe_stage_reg_if #(.DATA_W(DW), .MC_W(MW), .CNT_W(CW), .BCNT_W(4))  bus0 ();
   pipe_stage_reg_if #(.DATA_W(DW), .MC_W(MW), .CNT_W(CW), .BCNT_W(16)) bus1 ();

   assign bus0.stall = stall;    assign bus1.stall = stall;
   assign bus0.flush = flush;    assign bus1.flush = flush;
   assign bus0.in_valid = in_valid;  assign bus1.in_valid = in_valid;
   assign bus0.in_pld = in_pld;  assign bus1.in_pld = in_pld;
   assign bus0.mc_i = mc_i;      assign bus1.mc_i = mc_i;
   assign bus0.mc_cnt_i = mc_cnt_i;  assign bus1.mc_cnt_i = mc_cnt_i;
   assign bus0.cnt_clr = cnt_clr;    assign bus1.cnt_clr = cnt_clr;

   pipe_stage_reg #(
      .DATA_W(DW), .MC_W(MW), .CNT_W(CW), .STAGE_IDX(3), .CLEAR_ON_BUBBLE(1'b1), .BCNT_W(4)
   ) u_dut0 (
      .clk (clk),
      .rst (rst_n),
      .bus (bus0)
   );

   pipe_stage_reg #(
      .DATA_W(DW), .MC_W(MW), .CNT_W(CW), .STAGE_IDX(1), .CLEAR_ON_BUBBLE(1'b0), .BCNT_W(16)
   ) u_dut1 (
      .clk (clk),
      .rst (rst_n),
      .bus (bus1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: one entry per instance.
   localparam int IDX [2] = '{3, 1};
   localparam bit CLR [2] = '{1'b1, 1'b0};
   localparam int BMAX[2] = '{15, 65535};

   logic          m_v  [2];
   logic [DW-1:0] m_pld[2];
   logic [MW-1:0] m_mc [2];
   logic [CW-1:0] m_cc [2];
   int            m_bc [2];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            m_v[i] = 1'b0; m_pld[i] = '0; m_mc[i] = '0; m_cc[i] = '0; m_bc[i] = 0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            bit s, n, bub;
            s   = stall[IDX[i]];
            n   = stall[IDX[i]+1];
            bub = !flush && s && !n;
            if (flush) begin
               m_v[i] = 1'b0; m_pld[i] = '0; m_mc[i] = '0; m_cc[i] = '0;
            end else if (bub) begin
               m_v[i] = 1'b0;
               if (CLR[i]) m_pld[i] = '0;
               m_mc[i] = mc_i; m_cc[i] = mc_cnt_i;
            end else if (!s) begin
               m_v[i] = in_valid; m_pld[i] = in_pld; m_mc[i] = '0; m_cc[i] = '0;
            end else begin
               m_mc[i] = mc_i; m_cc[i] = mc_cnt_i;
            end
            if (cnt_clr)     m_bc[i] = 0;
            else if (bub)    m_bc[i] = (m_bc[i] >= BMAX[i]) ? BMAX[i] : m_bc[i] + 1;
         end
      end
   end

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      chk("u0_valid", 256'(bus0.out_valid),  256'(m_v[0]));
      chk("u0_pld",   256'(bus0.out_pld),    256'(m_pld[0]));
      chk("u0_mc",    256'(bus0.mc_o),       256'(m_mc[0]));
      chk("u0_mccnt", 256'(bus0.mc_cnt_o),   256'(m_cc[0]));
      chk("u0_bcnt",  256'(bus0.bubble_cnt), 256'(m_bc[0]));
      chk("u1_valid", 256'(bus1.out_valid),  256'(m_v[1]));
      chk("u1_pld",   256'(bus1.out_pld),    256'(m_pld[1]));
      chk("u1_mc",    256'(bus1.mc_o),       256'(m_mc[1]));
      chk("u1_mccnt", 256'(bus1.mc_cnt_o),   256'(m_cc[1]));
      chk("u1_bcnt",  256'(bus1.bubble_cnt), 256'(m_bc[1]));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_u0_zero(input string tag);
      chk({tag, "_valid"}, 256'(bus0.out_valid),  256'd0);
      chk({tag, "_pld"},   256'(bus0.out_pld),    256'd0);
      chk({tag, "_mc"},    256'(bus0.mc_o),       256'd0);
      chk({tag, "_mccnt"}, 256'(bus0.mc_cnt_o),   256'd0);
   endtask

   localparam logic [DW-1:0] P1 = 175'h1234_5678_9abc_def0_1357_9bdf_2468_ace0_0f0f;
   localparam logic [DW-1:0] P2 = 175'h7abc_0000_1111_2222_3333_4444_5555_6666_7777;
   localparam logic [DW-1:0] P3 = 175'h0055_aa55_aa55_aa55_aa55_aa55_aa55_aa55_aa55;
   localparam logic [DW-1:0] P4 = 175'h0001_0002_0003_0004_0005_0006_0007_0008_0009;
   localparam logic [MW-1:0] MC = 64'hDEAD_BEEF_0000_0001;

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      stall    = '0;
      flush    = 1'b0;
      in_valid = 1'b0;
      in_pld   = '0;
      mc_i     = '0;
      mc_cnt_i = '0;
      cnt_clr  = 1'b0;

      #1;
      check_u0_zero("reset");
      chk("reset_bcnt", 256'(bus0.bubble_cnt), 256'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Advance
      stall = 6'b000000; in_valid = 1'b1; in_pld = P1; mc_i = 64'h55; mc_cnt_i = 2'd3;
      tick();
      chk("adv_valid", 256'(bus0.out_valid), 256'd1);
      chk("adv_pld",   256'(bus0.out_pld),   256'(P1));
      chk("adv_mc",    256'(bus0.mc_o),      256'd0);

      // Bubble on stage 3; stage 1 sees s=1,n=1 and holds
      stall = 6'b001111; mc_i = MC; mc_cnt_i = 2'd1;
      tick();
      chk("bub_valid", 256'(bus0.out_valid),  256'd0);
      chk("bub_pld",   256'(bus0.out_pld),    256'd0);
      chk("bub_mc",    256'(bus0.mc_o),       256'(MC));
      chk("bub_mccnt", 256'(bus0.mc_cnt_o),   256'd1);
      chk("bub_bcnt",  256'(bus0.bubble_cnt), 256'd1);
      chk("u1_hold_pld", 256'(bus1.out_pld),  256'(P1));

      // Hold for three cycles after loading P2
      stall = 6'b000000; in_pld = P2;
      tick();
      stall = 6'b011111;
      for (int k = 0; k < 3; k++) begin
         mc_i = 64'h1000 + 64'(k); mc_cnt_i = 2'(k);
         tick();
         chk("hold_pld",  256'(bus0.out_pld),    256'(P2));
         chk("hold_mc",   256'(bus0.mc_o),       256'(64'h1000 + 64'(k)));
         chk("hold_bcnt", 256'(bus0.bubble_cnt), 256'd1);
      end

      // Flush overrides a bubble condition
      flush = 1'b1; stall = 6'b001111; mc_i = MC;
      tick();
      check_u0_zero("flush");
      chk("flush_bcnt", 256'(bus0.bubble_cnt), 256'd1);
      flush = 1'b0;

      // Stage 1 with payload retained on bubble
      stall = 6'b000000; in_pld = P3;
      tick();
      stall = 6'b000010; in_pld = P4;
      tick();
      chk("u1_bub_valid", 256'(bus1.out_valid), 256'd0);
      chk("u1_bub_pld",   256'(bus1.out_pld),   256'(P3));
      chk("u0_adv_pld",   256'(bus0.out_pld),   256'(P4));

      // Saturation of the 4-bit counter, then clear beating a bubble
      stall = 6'b000000; cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0; stall = 6'b001111;
      repeat (20) tick();
      chk("sat_bcnt", 256'(bus0.bubble_cnt), 256'd15);
      cnt_clr = 1'b1;
      tick();
      chk("clr_bcnt", 256'(bus0.bubble_cnt), 256'd0);
      cnt_clr = 1'b0;

      // Async reset in the middle of a multi-cycle hold
      stall = 6'b011111; mc_i = MC; mc_cnt_i = 2'd2;
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      check_u0_zero("arst");
      chk("arst_bcnt", 256'(bus0.bubble_cnt), 256'd0);
      @(negedge clk);
      rst_n = 1'b1;
      stall = 6'b000000; in_valid = 1'b1; in_pld = P4;
      tick();
      chk("post_rst_valid", 256'(bus0.out_valid), 256'd1);
      chk("post_rst_pld",   256'(bus0.out_pld),   256'(P4));
      chk("post_rst_mc",    256'(bus0.mc_o),      256'd0);

      // Randomized traffic, checked every cycle by the model comparison
      for (int k = 0; k < 600; k++) begin
         stall    = 6'($urandom);
         flush    = ($urandom_range(0, 9) == 0);
         cnt_clr  = ($urandom_range(0, 19) == 0);
         in_valid = 1'($urandom);
         in_pld   = DW'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
         mc_i     = {$urandom, $urandom};
         mc_cnt_i = 2'($urandom);
         if ($urandom_range(0, 49) == 0) begin
            #2;
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
         end
         tick();
      end

      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
